// File: rtl/axis_downsizer_n.sv
// ---------------------------------------------------------------------------
// axis_downsizer_n
// Single-clock AXI-Stream width downsizer. Each WIDTH_S*RATIO input beat is
// split into RATIO lanes of WIDTH_S bits and emitted one lane per cycle, in an
// order selected by cfg at the input handshake:
//   00 lane 0 only, 01 lane RATIO-1 only,
//   10 kept lanes ascending, 11 kept lanes descending.
// A zero-keep beat in modes 10/11 is swallowed and flagged on err_drop.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   cfg            lane-selection mode, sampled on input handshake only
//   p_axis_*       wide input stream (data, keep, valid, last, ready)
//   s_axis_*       narrow output stream (data, valid, last, ready)
//   err_drop       one-cycle pulse after a zero-keep beat is discarded
// ---------------------------------------------------------------------------
module axis_downsizer_n #(
    parameter int unsigned WIDTH_S = 32,
    parameter int unsigned RATIO   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 cfg,
    input  logic [WIDTH_S*RATIO-1:0]   p_axis_data,
    input  logic [RATIO-1:0]           p_axis_keep,
    input  logic                       p_axis_valid,
    input  logic                       p_axis_last,
    output logic                       p_axis_ready,
    output logic [WIDTH_S-1:0]         s_axis_data,
    output logic                       s_axis_valid,
    output logic                       s_axis_last,
    input  logic                       s_axis_ready,
    output logic                       err_drop
);

    localparam int unsigned IN_W = WIDTH_S * RATIO;
    localparam int unsigned IW   = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   data_q,  data_d;
    logic              last_q,  last_d;
    logic              desc_q,  desc_d;     // descending lane order for the held beat
    logic [RATIO-1:0]  rem_q,   rem_d;      // lanes still to emit after the current one
    logic [IW-1:0]     idx_q,   idx_d;      // lane currently presented on s_axis
    logic              out_last_q, out_last_d;
    logic              err_q,   err_d;

    logic              hs;
    logic              accept;
    logic              final_lane;
    logic              ld_any;
    logic [IW-1:0]     ld_idx;
    logic [RATIO-1:0]  ld_rem;
    logic [IW-1:0]     nxt_idx;
    logic [RATIO-1:0]  nxt_rem;

    // First set bit of m: lowest when desc=0, highest when desc=1.
    function automatic logic [IW-1:0] pick(input logic [RATIO-1:0] m, input logic desc);
        logic found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (m[i] && (desc || !found)) begin
                pick  = IW'(i);
                found = 1'b1;
            end
        end
    endfunction

    function automatic logic [RATIO-1:0] lane_bit(input logic [IW-1:0] i);
        lane_bit    = '0;
        lane_bit[i] = 1'b1;
    endfunction

    assign s_axis_valid = (state_q == SEND);
    assign s_axis_data  = data_q[idx_q*WIDTH_S +: WIDTH_S];
    assign s_axis_last  = out_last_q;
    assign err_drop     = err_q;

    // A beat is finished once no lanes remain beyond the one on the output.
    assign final_lane   = (rem_q == '0);
    assign accept       = s_axis_valid && s_axis_ready;
    assign p_axis_ready = !rst && ((state_q == IDLE) || (accept && final_lane));
    assign hs           = p_axis_valid && p_axis_ready;

    // Lane plan for the incoming beat: first lane and the set still to follow.
    always_comb begin
        ld_any = 1'b1;
        ld_idx = '0;
        ld_rem = '0;
        unique case (cfg)
            2'b00: ld_idx = '0;
            2'b01: ld_idx = IW'(RATIO - 1);
            default: begin
                ld_any = |p_axis_keep;
                ld_idx = pick(p_axis_keep, cfg[0]);
                ld_rem = p_axis_keep & ~lane_bit(pick(p_axis_keep, cfg[0]));
            end
        endcase
    end

    // Next kept lane of the held beat, found without a bubble per skipped lane.
    always_comb begin
        nxt_idx = pick(rem_q, desc_q);
        nxt_rem = rem_q & ~lane_bit(nxt_idx);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        last_d     = last_q;
        desc_d     = desc_q;
        rem_d      = rem_q;
        idx_d      = idx_q;
        out_last_d = out_last_q;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: ;
            SEND: begin
                if (accept) begin
                    if (!final_lane) begin
                        idx_d      = nxt_idx;
                        rem_d      = nxt_rem;
                        out_last_d = last_q && (nxt_rem == '0);
                    end else begin
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Handshake only occurs when idle or on the final lane, so it overrides.
        if (hs) begin
            if (ld_any) begin
                state_d    = SEND;
                data_d     = p_axis_data;
                last_d     = p_axis_last;
                desc_d     = cfg[0];
                idx_d      = ld_idx;
                rem_d      = ld_rem;
                out_last_d = p_axis_last && (ld_rem == '0);
            end else begin
                state_d    = IDLE;
                err_d      = 1'b1;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            last_q     <= 1'b0;
            desc_q     <= 1'b0;
            rem_q      <= '0;
            idx_q      <= '0;
            out_last_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            last_q     <= last_d;
            desc_q     <= desc_d;
            rem_q      <= rem_d;
            idx_q      <= idx_d;
            out_last_q <= out_last_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_axis_downsizer_n.sv
module tb_axis_downsizer_n;

    localparam int unsigned W  = 32;
    localparam int unsigned R  = 4;
    localparam int unsigned DW = W * R;

    localparam logic [W-1:0] LA = 32'hAAAA_AAAA;
    localparam logic [W-1:0] LB = 32'hBBBB_BBBB;
    localparam logic [W-1:0] LC = 32'hCCCC_CCCC;
    localparam logic [W-1:0] LD = 32'hDDDD_DDDD;
    localparam logic [W-1:0] L1 = 32'h1111_1111;
    localparam logic [W-1:0] L2 = 32'h2222_2222;
    localparam logic [W-1:0] L3 = 32'h3333_3333;
    localparam logic [W-1:0] L4 = 32'h4444_4444;
    localparam logic [DW-1:0] DAT1 = {LD, LC, LB, LA};
    localparam logic [DW-1:0] DAT2 = {L4, L3, L2, L1};

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    cfg;
    logic [DW-1:0] p_axis_data;
    logic [R-1:0]  p_axis_keep;
    logic          p_axis_valid;
    logic          p_axis_last;
    logic          p_axis_ready;
    logic [W-1:0]  s_axis_data;
    logic          s_axis_valid;
    logic          s_axis_last;
    logic          s_axis_ready;
    logic          err_drop;

    int errors = 0;
    int checks = 0;

    axis_downsizer_n #(.WIDTH_S(W), .RATIO(R)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg          (cfg),
        .p_axis_data  (p_axis_data),
        .p_axis_keep  (p_axis_keep),
        .p_axis_valid (p_axis_valid),
        .p_axis_last  (p_axis_last),
        .p_axis_ready (p_axis_ready),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_last  (s_axis_last),
        .s_axis_ready (s_axis_ready),
        .err_drop     (err_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of lanes still owed on the output.
    logic [W-1:0] mq_d[$];
    logic         mq_l[$];
    logic         err_exp = 1'b0;

    task automatic model_push(input logic [1:0] c, input logic [R-1:0] k,
                              input logic [DW-1:0] d, input logic l);
        int n0;
        n0 = mq_d.size();
        case (c)
            2'd0: begin mq_d.push_back(d[0 +: W]);         mq_l.push_back(1'b0); end
            2'd1: begin mq_d.push_back(d[(R-1)*W +: W]);   mq_l.push_back(1'b0); end
            2'd2: for (int i = 0; i < int'(R); i++)
                      if (k[i]) begin mq_d.push_back(d[i*W +: W]); mq_l.push_back(1'b0); end
            default: for (int i = int'(R) - 1; i >= 0; i--)
                      if (k[i]) begin mq_d.push_back(d[i*W +: W]); mq_l.push_back(1'b0); end
        endcase
        if (mq_d.size() > n0 && l) mq_l[mq_l.size()-1] = 1'b1;
    endtask

    // Every cycle: compare DUT against the model, then advance the model.
    always @(negedge clk) begin : mon
        logic rdy_exp;
        rdy_exp = !rst && (mq_d.size() == 0 || (mq_d.size() == 1 && s_axis_ready));
        check("mon_s_valid", DW'(s_axis_valid), DW'(mq_d.size() != 0));
        if (mq_d.size() != 0) begin
            check("mon_s_data", DW'(s_axis_data), DW'(mq_d[0]));
            check("mon_s_last", DW'(s_axis_last), DW'(mq_l[0]));
        end
        check("mon_p_ready", DW'(p_axis_ready), DW'(rdy_exp));
        check("mon_err_drop", DW'(err_drop), DW'(err_exp));
        err_exp = 1'b0;
        if (rst) begin
            mq_d.delete();
            mq_l.delete();
        end else begin
            if (mq_d.size() != 0 && s_axis_ready) begin
                void'(mq_d.pop_front());
                void'(mq_l.pop_front());
            end
            if (p_axis_valid && rdy_exp) begin
                model_push(cfg, p_axis_keep, p_axis_data, p_axis_last);
                if (cfg[1] && p_axis_keep == '0) err_exp = 1'b1;
            end
        end
    end

    typedef struct packed {
        logic [1:0]           cfg;
        logic [R-1:0]         keep;
        logic [DW-1:0]        data;
        logic                 last;
        logic [2:0]           n;
        logic [R-1:0][W-1:0]  ed;    // ed[k] = k-th expected output lane
        logic [R-1:0]         el;
        logic                 err;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] c, input logic [R-1:0] k, input logic [DW-1:0] d,
                                input logic l, input logic [2:0] n, input logic [R-1:0][W-1:0] ed,
                                input logic [R-1:0] el, input logic e);
        mk = '{cfg: c, keep: k, data: d, last: l, n: n, ed: ed, el: el, err: e};
    endfunction

    // Single beat from idle with s_axis_ready high; call at posedge+1.
    task automatic send_beat(input vec_t v, input string tag);
        cfg = v.cfg; p_axis_keep = v.keep; p_axis_data = v.data;
        p_axis_last = v.last; p_axis_valid = 1'b1; s_axis_ready = 1'b1;
        @(posedge clk); #1;
        p_axis_valid = 1'b0;
        for (int k = 0; k < int'(v.n); k++) begin
            @(negedge clk);
            check({tag, "_valid"}, DW'(s_axis_valid), DW'(1'b1));
            check({tag, "_data"},  DW'(s_axis_data),  DW'(v.ed[k]));
            check({tag, "_last"},  DW'(s_axis_last),  DW'(v.el[k]));
            if (k == 0) check({tag, "_err"}, DW'(err_drop), DW'(v.err));
        end
        @(negedge clk);
        check({tag, "_idle"}, DW'(s_axis_valid), DW'(1'b0));
        if (v.n == 0) begin
            check({tag, "_err"}, DW'(err_drop), DW'(v.err));
            @(negedge clk);
            check({tag, "_err_once"}, DW'(err_drop), DW'(1'b0));
        end
        @(posedge clk); #1;
    endtask

    vec_t vecs[9];
    logic [DW-1:0] bb[4];
    logic [3:0]    ll;

    initial begin
        rst = 1'b1; cfg = '0; p_axis_data = '0; p_axis_keep = '0;
        p_axis_valid = 1'b0; p_axis_last = 1'b0; s_axis_ready = 1'b1;

        vecs[0] = mk(2'b10, 4'b0011, DAT1, 1'b1, 3'd2, {W'(0), W'(0), LB, LA}, 4'b0010, 1'b0);
        vecs[1] = mk(2'b11, 4'b0101, DAT1, 1'b1, 3'd2, {W'(0), W'(0), LA, LC}, 4'b0010, 1'b0);
        vecs[2] = mk(2'b00, 4'b0000, DAT1, 1'b1, 3'd1, {W'(0), W'(0), W'(0), LA}, 4'b0001, 1'b0);
        vecs[3] = mk(2'b01, 4'b0000, DAT1, 1'b0, 3'd1, {W'(0), W'(0), W'(0), LD}, 4'b0000, 1'b0);
        vecs[4] = mk(2'b10, 4'b1111, DAT2, 1'b0, 3'd4, {L4, L3, L2, L1}, 4'b0000, 1'b0);
        vecs[5] = mk(2'b11, 4'b1010, DAT1, 1'b1, 3'd2, {W'(0), W'(0), LB, LD}, 4'b0010, 1'b0);
        vecs[6] = mk(2'b10, 4'b0000, DAT1, 1'b0, 3'd0, '0, 4'b0000, 1'b1);
        vecs[7] = mk(2'b10, 4'b1000, DAT1, 1'b1, 3'd1, {W'(0), W'(0), W'(0), LD}, 4'b0001, 1'b0);
        vecs[8] = mk(2'b11, 4'b1111, DAT2, 1'b1, 3'd4, {L1, L2, L3, L4}, 4'b1000, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", DW'(s_axis_valid), DW'(1'b0));
        check("rst_data",  DW'(s_axis_data),  DW'(0));
        check("rst_last",  DW'(s_axis_last),  DW'(1'b0));
        check("rst_err",   DW'(err_drop),     DW'(1'b0));
        check("rst_ready", DW'(p_axis_ready), DW'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Table of single beats
        for (int i = 0; i < 9; i++) send_beat(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back beats in mode 00
        ll = 4'b1010;
        for (int k = 0; k < 4; k++) bb[k] = {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < 4; k++) begin
            cfg = 2'b00; p_axis_data = bb[k]; p_axis_last = ll[k]; p_axis_valid = 1'b1;
            @(negedge clk);
            check("b2b_ready", DW'(p_axis_ready), DW'(1'b1));
            if (k > 0) begin
                check("b2b_valid", DW'(s_axis_valid), DW'(1'b1));
                check("b2b_data",  DW'(s_axis_data),  DW'(bb[k-1][W-1:0]));
                check("b2b_last",  DW'(s_axis_last),  DW'(ll[k-1]));
            end
            @(posedge clk); #1;
        end
        p_axis_valid = 1'b0;
        @(negedge clk);
        check("b2b_data",  DW'(s_axis_data), DW'(bb[3][W-1:0]));
        check("b2b_last",  DW'(s_axis_last), DW'(ll[3]));
        @(posedge clk); #1;

        // Stall on lane 0 with cfg toggling
        cfg = 2'b10; p_axis_keep = 4'b1111; p_axis_data = DAT1; p_axis_last = 1'b1;
        p_axis_valid = 1'b1; s_axis_ready = 1'b0;
        @(posedge clk); #1;
        p_axis_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", DW'(s_axis_valid), DW'(1'b1));
            check("stall_data",  DW'(s_axis_data),  DW'(LA));
            check("stall_ready", DW'(p_axis_ready), DW'(1'b0));
            @(posedge clk); #1;
            cfg = cfg ^ 2'b11;
        end
        s_axis_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            check("stall_order", DW'(s_axis_data), DW'(DAT1[j*W +: W]));
            check("stall_olast", DW'(s_axis_last), DW'(j == 3));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("stall_done", DW'(s_axis_valid), DW'(1'b0));
        @(posedge clk); #1;

        // Reset mid-beat after lane 0 accepted
        cfg = 2'b10; p_axis_keep = 4'b1111; p_axis_data = DAT1; p_axis_last = 1'b1;
        p_axis_valid = 1'b1; s_axis_ready = 1'b1;
        @(posedge clk); #1;
        p_axis_valid = 1'b0;
        @(negedge clk);
        check("mrst_lane0", DW'(s_axis_data), DW'(LA));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mrst_ready", DW'(p_axis_ready), DW'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mrst_valid", DW'(s_axis_valid), DW'(1'b0));
        check("mrst_data",  DW'(s_axis_data),  DW'(0));
        @(posedge clk); #1;
        send_beat(mk(2'b11, 4'b0110, DAT1, 1'b1, 3'd2, {W'(0), W'(0), LB, LC}, 4'b0010, 1'b0), "mrst_next");

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            p_axis_valid = ($urandom_range(0, 3) != 0);
            s_axis_ready = ($urandom_range(0, 3) != 0);
            cfg          = 2'($urandom_range(0, 3));
            p_axis_keep  = R'($urandom_range(0, 15));
            p_axis_data  = {$urandom, $urandom, $urandom, $urandom};
            p_axis_last  = 1'($urandom_range(0, 1));
            rst          = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; p_axis_valid = 1'b0; s_axis_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("drain_empty", DW'(mq_d.size()), DW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
